// File: rtl/serdesphy_rx_pkg.sv
// Shared state encoding, counter widths and defaults for the SerDes receive
// word-alignment and lock controller.
package serdesphy_rx_pkg;

   localparam int unsigned STATE_W      = 3;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned SLIP_CNT_W   = 4;
   localparam int unsigned GOOD_CNT_W   = 4;
   localparam int unsigned ERR_CNT_W    = 4;
   localparam int unsigned SETTLE_CNT_W = 4;
   localparam int unsigned LOSS_CNT_W   = 8;

   localparam logic [STATE_W-1:0] ST_DISABLED  = 3'd0;
   localparam logic [STATE_W-1:0] ST_HUNT      = 3'd1;
   localparam logic [STATE_W-1:0] ST_SLIP_WAIT = 3'd2;
   localparam logic [STATE_W-1:0] ST_VERIFY    = 3'd3;
   localparam logic [STATE_W-1:0] ST_LOCKED    = 3'd4;

   localparam logic [DATA_W-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/serdesphy_sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous active-low reset.
module serdesphy_sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/serdesphy_rx_lock_controller.sv
// Receive word-alignment controller: hunts for the sync byte with bit-slips,
// verifies a run of clean words, then forwards data until repeated errors.
module serdesphy_rx_lock_controller
   import serdesphy_rx_pkg::*;
#(
   parameter logic [DATA_W-1:0] SYNC_BYTE       = DEFAULT_SYNC_BYTE,
   parameter int unsigned       LOCK_GOOD_COUNT = 4,
   parameter int unsigned       LOSS_ERR_COUNT  = 3,
   parameter int unsigned       SLIP_SETTLE     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [DATA_W-1:0]     decoded_data,
   input  logic                  decode_valid,
   input  logic                  decode_error,
   output logic                  bitslip,
   output logic                  rx_locked,
   output logic [DATA_W-1:0]     rx_data,
   output logic                  rx_valid,
   output logic                  rx_err,
   output logic [SLIP_CNT_W-1:0] slip_count,
   output logic                  hunt_wrap,
   output logic [LOSS_CNT_W-1:0] lock_loss_count,
   output logic [STATE_W-1:0]    state
);

   localparam logic [GOOD_CNT_W-1:0]   GOOD_TARGET = GOOD_CNT_W'(LOCK_GOOD_COUNT);
   localparam logic [ERR_CNT_W-1:0]    LOSS_TARGET = ERR_CNT_W'(LOSS_ERR_COUNT);
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SLIP_SETTLE - 1);
   localparam bit                      DIRECT_LOCK = (LOCK_GOOD_COUNT == 1);

   logic [STATE_W-1:0]      state_d;
   logic [GOOD_CNT_W-1:0]   good_cnt, good_cnt_d, good_inc;
   logic [ERR_CNT_W-1:0]    err_cnt, err_cnt_d, err_inc;
   logic [SETTLE_CNT_W-1:0] settle_cnt, settle_cnt_d;
   logic [SLIP_CNT_W-1:0]   slip_count_d;
   logic [DATA_W-1:0]       rx_data_d;
   logic                    bitslip_d, rx_locked_d, rx_valid_d, rx_err_d, hunt_wrap_d;
   logic                    sync_hit, slip_req, loss_inc;

   assign sync_hit = !decode_error && (decoded_data == SYNC_BYTE);
   assign good_inc = good_cnt + GOOD_CNT_W'(1);
   assign err_inc  = err_cnt + ERR_CNT_W'(1);
   assign slip_req = enable && decode_valid &&
                     (((state == ST_HUNT) && !sync_hit) ||
                      ((state == ST_VERIFY) && decode_error));

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ST_DISABLED;
      else
         state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (!enable) begin
         state_d = ST_DISABLED;
      end else begin
         case (state)
            ST_DISABLED:  state_d = ST_HUNT;
            ST_HUNT:
               if (decode_valid)
                  state_d = sync_hit ? (DIRECT_LOCK ? ST_LOCKED : ST_VERIFY) : ST_SLIP_WAIT;
            ST_SLIP_WAIT:
               if (settle_cnt == SETTLE_LAST) state_d = ST_HUNT;
            ST_VERIFY:
               if (decode_valid) begin
                  if (decode_error)              state_d = ST_SLIP_WAIT;
                  else if (good_inc == GOOD_TARGET) state_d = ST_LOCKED;
               end
            ST_LOCKED:
               if (decode_valid && decode_error && (err_inc == LOSS_TARGET))
                  state_d = ST_HUNT;
            default:      state_d = ST_DISABLED;
         endcase
      end
   end

   // Next values for registered outputs and internal counters.
   always_comb begin
      bitslip_d    = 1'b0;
      rx_valid_d   = 1'b0;
      rx_err_d     = 1'b0;
      rx_locked_d  = rx_locked;
      rx_data_d    = rx_data;
      slip_count_d = slip_count;
      hunt_wrap_d  = hunt_wrap;
      good_cnt_d   = good_cnt;
      err_cnt_d    = err_cnt;
      settle_cnt_d = settle_cnt;
      loss_inc     = 1'b0;
      if (!enable) begin
         rx_locked_d  = 1'b0;
         slip_count_d = '0;
         hunt_wrap_d  = 1'b0;
         good_cnt_d   = '0;
         err_cnt_d    = '0;
         settle_cnt_d = '0;
      end else begin
         case (state)
            ST_DISABLED: slip_count_d = '0;
            ST_HUNT:
               if (decode_valid && sync_hit) begin
                  good_cnt_d = GOOD_CNT_W'(1);
                  if (DIRECT_LOCK) begin
                     rx_locked_d = 1'b1;
                     err_cnt_d   = '0;
                  end
               end
            ST_SLIP_WAIT:
               settle_cnt_d = (settle_cnt == SETTLE_LAST) ? '0 : settle_cnt + SETTLE_CNT_W'(1);
            ST_VERIFY:
               if (decode_valid && !decode_error) begin
                  if (good_inc == GOOD_TARGET) begin
                     rx_locked_d = 1'b1;
                     err_cnt_d   = '0;
                  end else begin
                     good_cnt_d = good_inc;
                  end
               end
            ST_LOCKED:
               if (decode_valid) begin
                  if (!decode_error) begin
                     rx_data_d  = decoded_data;
                     rx_valid_d = 1'b1;
                     err_cnt_d  = '0;
                  end else begin
                     rx_err_d  = 1'b1;
                     err_cnt_d = err_inc;
                     if (err_inc == LOSS_TARGET) begin
                        rx_locked_d  = 1'b0;
                        loss_inc     = 1'b1;
                        slip_count_d = '0;
                        err_cnt_d    = '0;
                     end
                  end
               end
            default: ;
         endcase
         if (slip_req) begin
            bitslip_d    = 1'b1;
            slip_count_d = slip_count + SLIP_CNT_W'(1);
            settle_cnt_d = '0;
            if (slip_count == '1) hunt_wrap_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bitslip    <= 1'b0;
         rx_locked  <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_err     <= 1'b0;
         slip_count <= '0;
         hunt_wrap  <= 1'b0;
         good_cnt   <= '0;
         err_cnt    <= '0;
         settle_cnt <= '0;
      end else begin
         bitslip    <= bitslip_d;
         rx_locked  <= rx_locked_d;
         rx_data    <= rx_data_d;
         rx_valid   <= rx_valid_d;
         rx_err     <= rx_err_d;
         slip_count <= slip_count_d;
         hunt_wrap  <= hunt_wrap_d;
         good_cnt   <= good_cnt_d;
         err_cnt    <= err_cnt_d;
         settle_cnt <= settle_cnt_d;
      end
   end

   serdesphy_sat_counter #(.W(LOSS_CNT_W)) u_loss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .inc   (loss_inc),
      .count (lock_loss_count)
   );

endmodule
